stream_mux_rr: RTL and testbench

Parametrised N-input, W-bit stream multiplexer with a valid/ready handshake on every channel and one registered output stage.
- The datapath is built from narrow SLICE_W-bit N:1 slice muxes, concatenated to full width.
- A runtime mode bit chooses the channel source: external select or round-robin arbitration among valid inputs.
- It sits between parallel producer streams and a single downstream consumer.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/stream_mux_rr_if.sv | 34 +++
 rtl/mux_n_1_slice.sv | 24 ++
 rtl/stream_mux_rr.sv | 108 ++++++++++
 tb/tb_stream_mux_rr.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode encoding and round-robin pointer helper
// Purpose: constants and helpers shared by the stream multiplexer files.
// Ports: none (package).
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;  // external select
  localparam logic MODE_RR  = 1'b1;  // round-robin among valid inputs

  // Advance a channel index by one, wrapping n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - handshake bundle between producers, mux and consumer
// Purpose: groups the per-channel input streams, the mode/select controls and
//          the single output stream of stream_mux_rr.
// Ports (signals):
//   rr_mode, sel         - arbitration mode and external channel select
//   in_valid/in_data     - N_IN producer streams, channel i at in_data[i*W +: W]
//   in_ready             - per-channel ready from the mux
//   out_valid/out_data/out_src/out_ready - registered output stream
// Modports: master = environment (producers + consumer), slave = the mux.
interface stream_mux_rr_if #(
  parameter int N_IN  = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_IN)
);
  logic              rr_mode;
  logic [SEL_W-1:0]  sel;
  logic [N_IN-1:0]   in_valid;
  logic [N_IN*W-1:0] in_data;
  logic [N_IN-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_src;
  logic              out_ready;

  modport master (
    output rr_mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  rr_mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_n_1_slice.sv
// rtl/mux_n_1_slice.sv - combinational N:1 mux for one SLICE_W-bit data slice
// Purpose: selects slice sel out of N_IN packed slices.
// Ports:
//   sel  - channel index (out-of-range selects yield zero)
//   din  - N_IN slices, slice i at din[i*SLICE_W +: SLICE_W]
//   dout - selected slice
module mux_n_1_slice #(
  parameter int N_IN    = 4,
  parameter int SLICE_W = 2,
  parameter int SEL_W   = $clog2(N_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_IN*SLICE_W-1:0] din,
  output logic [SLICE_W-1:0]      dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) dout = din[i*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-input stream mux, external select or round-robin, registered output
// Purpose: picks one valid input channel per cycle and moves its beat into a
//          single output register; datapath built from SLICE_W-bit slice muxes.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - stream_mux_rr_if slave: rr_mode, sel, in_valid, in_data, in_ready,
//           out_valid, out_data, out_src, out_ready
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int W       = 8,
  parameter int SLICE_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_rr_if.slave bus
);

  localparam int SEL_W   = $clog2(N_IN);
  localparam int N_SLICE = W / SLICE_W;

  if (W % SLICE_W != 0) begin : g_width_check
    $error("stream_mux_rr: W must be a multiple of SLICE_W");
  end

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic             load_en;
  logic             sel_ok;
  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  logic [SEL_W-1:0] out_src_q;
  logic [W-1:0]     mux_data;

  // Register may take a new beat when empty or when being drained this cycle.
  assign load_en = !out_valid_q || bus.out_ready;
  assign sel_ok  = (32'(bus.sel) < 32'(N_IN));

  always_comb begin
    int j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (bus.rr_mode == MODE_RR) begin
      grant_vld = |bus.in_valid;
      // Walk from the farthest offset down so the channel closest to rr_ptr wins.
      for (int k = N_IN - 1; k >= 0; k--) begin
        j = int'(rr_ptr) + k;
        if (j >= N_IN) j = j - N_IN;
        if (bus.in_valid[j]) grant_idx = SEL_W'(j);
      end
    end else begin
      grant_idx = bus.sel;
      if (sel_ok) grant_vld = bus.in_valid[bus.sel];
    end
  end

  // Held low in reset so no producer believes a beat was taken.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      bus.in_ready[i] = rst_n && load_en && grant_vld && (grant_idx == SEL_W'(i));
    end
  end

  for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
    logic [N_IN*SLICE_W-1:0] slice_in;
    for (genvar i = 0; i < N_IN; i++) begin : g_ch
      assign slice_in[i*SLICE_W +: SLICE_W] = bus.in_data[i*W + s*SLICE_W +: SLICE_W];
    end
    mux_n_1_slice #(
      .N_IN    (N_IN),
      .SLICE_W (SLICE_W),
      .SEL_W   (SEL_W)
    ) u_mux (
      .sel  (grant_idx),
      .din  (slice_in),
      .dout (mux_data[s*SLICE_W +: SLICE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr      <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mux_data;
        out_src_q   <= grant_idx;
        if (bus.rr_mode == MODE_RR) begin
          rr_ptr <= SEL_W'(rr_next(32'(grant_idx), N_IN));
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - scoreboard bench for stream_mux_rr against a queue-based reference model
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   src;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.N_IN(4), .W(8)) bus ();
  stream_mux_rr_if #(.N_IN(3), .W(8)) bus3 ();

  stream_mux_rr #(.N_IN(4), .W(8), .SLICE_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  stream_mux_rr #(.N_IN(3), .W(8), .SLICE_W(2)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  int    vectors = 0;
  int    miscompares = 0;
  beat_t q[$];
  bit    m_full = 1'b0;
  int    m_ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: scan channels starting at the pointer.
  task automatic ref_grant(input bit rr, input int sel, input logic [N-1:0] valid,
                           output bit gv, output int gi);
    gv = 1'b0;
    gi = 0;
    if (rr) begin
      for (int k = 0; k < N; k++) begin
        if (!gv && valid[(m_ptr + k) % N]) begin
          gv = 1'b1;
          gi = (m_ptr + k) % N;
        end
      end
    end else begin
      gi = sel;
      gv = (sel < N) && valid[sel];
    end
  endtask

  // One cycle: drive inputs, check in_ready against the model, record accepted beat.
  task automatic step(input bit rst, input bit rr, input int sel, input logic [N-1:0] valid,
                      input logic [N*W-1:0] data, input bit oready);
    bit gv;
    int gi;
    bit load;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #2;
    rst_n        = !rst;
    bus.rr_mode  = rr;
    bus.sel      = 2'(sel);
    bus.in_valid = valid;
    bus.in_data  = data;
    bus.out_ready = oready;
    #1;
    if (rst) begin
      q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
      chk("in_ready_rst", 32'(bus.in_ready), 32'h0);
    end else begin
      ref_grant(rr, sel, valid, gv, gi);
      load = !m_full || oready;
      exp_rdy = (load && gv) ? (4'b0001 << gi) : 4'b0000;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (load) begin
        if (gv) begin
          q.push_back('{data: data[gi*W +: W], src: 2'(gi)});
          m_full = 1'b1;
          if (rr) m_ptr = (gi + 1) % N;
        end else begin
          m_full = 1'b0;
        end
      end
    end
  endtask

  // Monitor: compares the output register with the head of the scoreboard,
  // and retires the head once the consumer has accepted it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_out_src", 32'(bus.out_src), 32'h0);
      end else begin
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (bus.out_valid && q.size() != 0) begin
          chk("out_data", 32'(bus.out_data), 32'(q[0].data));
          chk("out_src", 32'(bus.out_src), 32'(q[0].src));
        end
      end
      #3;
      if (rst_n && bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  initial begin
    logic [N*W-1:0] d;
    bus.rr_mode = 1'b0;  bus.sel = '0;  bus.in_valid = '0;  bus.in_data = '0;  bus.out_ready = 1'b1;
    bus3.rr_mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b1;

    // Reset held with every channel valid.
    for (int i = 0; i < 2; i++) step(1, 1, 0, 4'hF, 32'h44332211, 1);

    // Fixed select of channel 2.
    step(0, 0, 2, 4'hF, 32'h11A52233, 1);
    step(0, 0, 2, 4'hF, 32'h11A52233, 1);

    // Round-robin fairness with all channels valid.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 4'hF, $urandom, 1);

    // Skip and wrap: move pointer to 3 via ch2, then ch1 only, ch2, ch3 only.
    step(0, 1, 0, 4'b0100, $urandom, 1);
    step(0, 1, 0, 4'b0010, $urandom, 1);
    step(0, 1, 0, 4'b0100, $urandom, 1);
    step(0, 1, 0, 4'b1000, $urandom, 1);
    step(0, 1, 0, 4'b0001, $urandom, 1);

    // Backpressure for three cycles, then release.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'hF, $urandom, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'hF, $urandom, 1);

    // Mid-transfer reset, then recovery.
    step(0, 1, 0, 4'hF, $urandom, 0);
    step(1, 1, 0, 4'hF, $urandom, 1);
    step(0, 1, 0, 4'hF, $urandom, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      d = {$urandom};
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
           4'($urandom), d, ($urandom_range(0, 9) < 7));
    end

    // Drain.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 4'h0, 32'h0, 1);
    chk("drained", 32'(q.size()), 32'h0);

    // Three-channel instance: out-of-range select grants nothing.
    @(posedge clk);
    #2;
    bus3.rr_mode = 1'b0; bus3.sel = 2'd0; bus3.in_valid = 3'b111; bus3.in_data = 24'h5A3C7E; bus3.out_ready = 1'b1;
    #1;
    chk("n3_ready_sel0", 32'(bus3.in_ready), 32'h1);
    @(posedge clk);
    #2;
    bus3.sel = 2'd3;
    #1;
    chk("n3_ready_sel3", 32'(bus3.in_ready), 32'h0);
    chk("n3_pending_valid", 32'(bus3.out_valid), 32'h1);
    chk("n3_pending_data", 32'(bus3.out_data), 32'h7E);
    chk("n3_pending_src", 32'(bus3.out_src), 32'h0);
    @(posedge clk);
    #3;
    chk("n3_drop_valid", 32'(bus3.out_valid), 32'h0);
    chk("n3_ready_still0", 32'(bus3.in_ready), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
